// File: rtl/exu_fpu_resp.sv
// exu_fpu_resp
//   Response-side collector for the FP32 execution unit. It accepts completed
//   results from the FPU over a valid/ready handshake and buffers them in a
//   small FIFO. It presents the head entry to the writeback port over its own
//   valid/ready handshake. It accrues IEEE exception flags as entries retire,
//   and it backpressures the FPU while the FIFO is full.
//
//   Optional feature: define EXU_FPU_RESP_BYPASS_EN to let a result arriving
//   at an empty collector reach writeback in the same cycle.
//
//   Parameters
//     DEPTH  FIFO entries (power of two, >= 2)
//     TAG_W  tag width (destination register index)
//
//   Ports
//     clk, rst        core clock, asynchronous active-high reset
//     flush           discard every buffered result
//     fpu_out_valid   FPU result valid
//     fpu_out_ready   collector can accept a result
//     fpu_result      FP32 result
//     fpu_status      {NV,DZ,OF,UF,NX}
//     fpu_tag         result tag
//     wb_valid        writeback entry valid
//     wb_ready        writeback accepts entry
//     wb_data         head-entry result
//     wb_tag          head-entry tag
//     wb_status       head-entry status
//     fflags_clr      clear accrued flags (CSR write)
//     fflags          sticky OR of retired status
//     count           occupancy
//     fpu_pending     count != 0
module exu_fpu_resp #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       fpu_out_valid,
    output logic                       fpu_out_ready,
    input  logic [31:0]                fpu_result,
    input  logic [4:0]                 fpu_status,
    input  logic [TAG_W-1:0]           fpu_tag,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [31:0]                wb_data,
    output logic [TAG_W-1:0]           wb_tag,
    output logic [4:0]                 wb_status,
    input  logic                       fflags_clr,
    output logic [4:0]                 fflags,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       fpu_pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic [4:0]       status;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic [4:0]      fflags_q;

    logic            not_empty;
    logic            push;
    logic            fifo_pop;
    logic            retire;
    logic            bypass_hit;
    logic            bypass_retire;

    assign not_empty = (count_q != '0);

`ifdef EXU_FPU_RESP_BYPASS_EN
    // An empty collector forwards an arriving result straight to writeback.
    // If writeback takes it that cycle, it never occupies a FIFO slot.
    assign bypass_hit    = ~not_empty & fpu_out_valid & ~flush;
    assign bypass_retire = bypass_hit & wb_ready;
`else
    assign bypass_hit    = 1'b0;
    assign bypass_retire = 1'b0;
`endif

    // Ready depends on registered occupancy only. While the FIFO is full, a
    // same-cycle pop does not reopen ready.
    assign fpu_out_ready = (count_q < CW'(DEPTH));
    assign wb_valid      = (not_empty & ~flush) | bypass_hit;
    assign fifo_pop      = not_empty & ~flush & wb_ready;
    assign retire        = wb_valid & wb_ready;
    assign push          = fpu_out_valid & fpu_out_ready & ~flush & ~bypass_retire;

    assign count       = count_q;
    assign fpu_pending = not_empty;
    assign fflags      = fflags_q;

    always_comb begin
        wb_data   = '0;
        wb_tag    = '0;
        wb_status = '0;
        if (not_empty) begin
            wb_data   = mem[rd_ptr].data;
            wb_tag    = mem[rd_ptr].tag;
            wb_status = mem[rd_ptr].status;
        end else if (bypass_hit) begin
            wb_data   = fpu_result;
            wb_tag    = fpu_tag;
            wb_status = fpu_status;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{data: fpu_result, tag: fpu_tag, status: fpu_status};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !fifo_pop) begin
                count_q <= count_q + CW'(1);
            end else if (fifo_pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // A clear and a retire in the same cycle keep the retiring flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= (fflags_clr ? 5'b0 : fflags_q) | (retire ? wb_status : 5'b0);
        end
    end

endmodule
